profir_bank_mc: RTL and testbench



---
 rtl/profir_pkg.sv | 28 ++
 rtl/profir_mac_lane.sv | 66 ++++++
 rtl/profir_bank_mc.sv | 115 +++++++++++
 tb/tb_profir_bank_mc.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/profir_pkg.sv
// Shared constants, state encoding and helpers for the profir multi-channel filter bank.
// Optional output saturation is selected with PROFIR_SAT_EN (see profir_mac_lane).
package profir_pkg;

    localparam int unsigned NCH_DEF      = 8;
    localparam int unsigned NTAPS_DEF    = 128;
    localparam int unsigned DW_DEF       = 16;
    localparam int unsigned CW_DEF       = 18;
    localparam int unsigned CPW_DEF      = 2;
    localparam int unsigned OUTSHIFT_DEF = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int unsigned NADDR = NTAPS_DEF / CPW_DEF;
    localparam int unsigned ACCW  = DW_DEF + CW_DEF + clog2(NTAPS_DEF);

endpackage

// File: rtl/profir_mac_lane.sv
// One filter channel: CPW signed multipliers, accumulator and output stage.
// With PROFIR_SAT_EN defined the shifted result is clamped, otherwise it wraps.
module profir_mac_lane
    import profir_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned CPW      = CPW_DEF,
    parameter int unsigned OUTSHIFT = OUTSHIFT_DEF,
    parameter int unsigned ACC_W    = ACCW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              mac_en,
    input  logic              load,
    input  logic [CPW*CW-1:0] coeffs,
    input  logic [CPW*DW-1:0] samples,
    output logic [DW-1:0]     dout
);

    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sum;
    logic signed [DW+CW-1:0]   prod [CPW];
    logic        [DW-1:0]      yout;

    always_comb begin
        sum = '0;
        for (int unsigned l = 0; l < CPW; l++) begin
            prod[l] = $signed(samples[l*DW +: DW]) * $signed(coeffs[l*CW +: CW]);
            sum = sum + {{(ACC_W-DW-CW){prod[l][DW+CW-1]}}, prod[l]};
        end
    end

`ifdef PROFIR_SAT_EN
    logic signed [ACC_W-1:0] shifted;

    // In range exactly when every bit from the DW-1 sign position upward agrees.
    always_comb begin
        shifted = acc >>> OUTSHIFT;
        if ((&shifted[ACC_W-1:DW-1]) || !(|shifted[ACC_W-1:DW-1]))
            yout = shifted[DW-1:0];
        else
            yout = {shifted[ACC_W-1], {(DW-1){~shifted[ACC_W-1]}}};
    end
`else
    always_comb begin
        yout = acc[OUTSHIFT +: DW];
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            dout <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (mac_en)
                acc <= acc + sum;
            if (load)
                dout <= yout;
        end
    end

endmodule

// File: rtl/profir_bank_mc.sv
// NCH-channel FIR bank: circular sample buffer, IDLE/RUN/DRAIN sequencer and shared coefficient addressing.
// Output saturation is enabled by defining PROFIR_SAT_EN.
module profir_bank_mc
    import profir_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned NTAPS    = NTAPS_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned CW       = CW_DEF,
    parameter int unsigned CPW      = CPW_DEF,
    parameter int unsigned OUTSHIFT = OUTSHIFT_DEF
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic signed [DW-1:0]          datain,
    input  logic                          din_enable,
    output logic [clog2(NTAPS/CPW)-1:0]   coeffaddress,
    input  logic [NCH*CPW*CW-1:0]         coeffdata,
    output logic [NCH*DW-1:0]             dataout,
    output logic                          dout_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int unsigned NWORDS = NTAPS / CPW;
    localparam int unsigned AW     = clog2(NWORDS);
    localparam int unsigned PW     = clog2(NTAPS);
    localparam int unsigned ACC_W  = DW + CW + PW;

    logic [1:0]        state;
    logic [PW-1:0]     wptr;
    logic [DW-1:0]     sbuf [NTAPS];
    logic [AW-1:0]     mac_addr;
    logic              mac_en;
    logic              mac_last;
    logic              load_q;
    logic              accept;
    logic [PW-1:0]     tap;
    logic [CPW*DW-1:0] smp;

    assign accept = din_enable && (state == IDLE);
    assign busy   = (state != IDLE);

    // MAC stage trails the address by one cycle, so its taps come from the delayed word address.
    always_comb begin
        smp = '0;
        tap = '0;
        for (int unsigned l = 0; l < CPW; l++) begin
            tap = PW'(CPW * mac_addr + l);
            smp[l*DW +: DW] = sbuf[wptr - PW'(1) - tap];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wptr         <= '0;
            coeffaddress <= '0;
            mac_addr     <= '0;
            mac_en       <= 1'b0;
            mac_last     <= 1'b0;
            load_q       <= 1'b0;
            dout_valid   <= 1'b0;
            overrun      <= 1'b0;
            for (int unsigned i = 0; i < NTAPS; i++) sbuf[i] <= '0;
        end else begin
            overrun    <= din_enable && (state != IDLE);
            mac_en     <= (state == RUN);
            mac_last   <= (state == RUN) && (coeffaddress == AW'(NWORDS - 1));
            load_q     <= mac_last;
            dout_valid <= load_q;
            mac_addr   <= coeffaddress;
            case (state)
                IDLE: begin
                    coeffaddress <= '0;
                    if (din_enable) begin
                        sbuf[wptr] <= datain;
                        wptr       <= wptr + PW'(1);
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (coeffaddress == AW'(NWORDS - 1)) begin
                        coeffaddress <= '0;
                        state        <= DRAIN;
                    end else begin
                        coeffaddress <= coeffaddress + AW'(1);
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        profir_mac_lane #(
            .DW       (DW),
            .CW       (CW),
            .CPW      (CPW),
            .OUTSHIFT (OUTSHIFT),
            .ACC_W    (ACC_W)
        ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (accept),
            .mac_en  (mac_en),
            .load    (load_q),
            .coeffs  (coeffdata[c*CPW*CW +: CPW*CW]),
            .samples (smp),
            .dout    (dataout[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_profir_bank_mc.sv
// Self-checking bench for profir_bank_mc against a direct-form convolution model.
// Expected output narrowing follows PROFIR_SAT_EN.
module tb_profir_bank_mc;

    localparam int NCH      = 8;
    localparam int NTAPS    = 128;
    localparam int DW       = 16;
    localparam int CW       = 18;
    localparam int CPW      = 2;
    localparam int OUTSHIFT = 16;
    localparam int AW       = 6;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic signed [DW-1:0]   datain;
    logic                   din_enable;
    logic [AW-1:0]          coeffaddress;
    logic [NCH*CPW*CW-1:0]  coeffdata;
    logic [NCH*DW-1:0]      dataout;
    logic                   dout_valid;
    logic                   busy;
    logic                   overrun;

    int h [NCH][NTAPS];
    int hist [$];
    int pass_cnt = 0;
    int total_cnt = 0;

    profir_bank_mc #(
        .NCH      (NCH),
        .NTAPS    (NTAPS),
        .DW       (DW),
        .CW       (CW),
        .CPW      (CPW),
        .OUTSHIFT (OUTSHIFT)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .datain       (datain),
        .din_enable   (din_enable),
        .coeffaddress (coeffaddress),
        .coeffdata    (coeffdata),
        .dataout      (dataout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    // Synchronous coefficient ROM: data appears one cycle after the address.
    always @(posedge clock) begin
        for (int c = 0; c < NCH; c++)
            for (int l = 0; l < CPW; l++)
                coeffdata[(c*CPW+l)*CW +: CW] <= CW'(h[c][CPW*int'(coeffaddress)+l]);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [DW-1:0] model_out(input int c);
        longint acc;
        longint ys;
        acc = 0;
        for (int k = 0; k < NTAPS; k++)
            if (k < hist.size())
                acc += longint'(h[c][k]) * longint'(hist[hist.size()-1-k]);
        ys = acc >>> OUTSHIFT;
`ifdef PROFIR_SAT_EN
        if (ys > 32767)  ys = 32767;
        if (ys < -32768) ys = -32768;
`endif
        return ys[DW-1:0];
    endfunction

    task automatic push_hist(input int s);
        hist.push_back(s);
        if (hist.size() > NTAPS) hist.delete(0);
    endtask

    task automatic send_sample(input int s);
        @(negedge clock);
        datain     = DW'(s);
        din_enable = 1'b1;
        @(posedge clock);
        #1;
        din_enable = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_out(output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (dout_valid) found = 1;
        end
        if (!found) n = -1;
    endtask

    task automatic apply_reset();
        din_enable = 1'b0;
        datain     = '0;
        reset_n    = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        hist.delete();
    endtask

    task automatic set_impulse();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++)
                h[c][k] = (k == c) ? 65536 : 0;
    endtask

    task automatic set_random_coeffs();
        logic signed [CW-1:0] t;
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++) begin
                t = CW'($urandom);
                h[c][k] = t;
            end
    endtask

    task automatic impulse_run(input string tag);
        int n;
        logic signed [DW-1:0] exp_v;
        set_impulse();
        for (int j = 1; j <= NCH; j++) begin
            send_sample(j == 1 ? 1000 : 0);
            wait_out(n);
            total_cnt++;
            if (n < 0) begin
                $display("FAIL %s_timeout output %0d: no dout_valid, required one", tag, j);
            end else begin
                pass_cnt++;
                for (int c = 0; c < NCH; c++) begin
                    exp_v = (j == c + 1) ? 16'sd1000 : 16'sd0;
                    total_cnt++;
                    if ($signed(dataout[c*DW +: DW]) !== exp_v)
                        $display("FAIL %s out%0d ch%0d: got %0d, required %0d", tag, j, c,
                                 $signed(dataout[c*DW +: DW]), exp_v);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic signed [DW-1:0] exp_v;
        for (int c = 0; c < NCH; c++) begin
            exp_v = model_out(c);
            total_cnt++;
            if ($signed(dataout[c*DW +: DW]) !== exp_v)
                $display("FAIL %s ch%0d: got %0d, required %0d", tag, c,
                         $signed(dataout[c*DW +: DW]), exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b1;
        din_enable = 1'b0;
        datain     = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++; if (dataout !== '0)      $display("FAIL reset_dataout: got %h, required 0", dataout); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b0) $display("FAIL reset_dout_valid: got %b, required 0", dout_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b, required 0", busy); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0)    $display("FAIL reset_overrun: got %b, required 0", overrun); else pass_cnt++;
        total_cnt++; if (coeffaddress !== '0) $display("FAIL reset_coeffaddress: got %0d, required 0", coeffaddress); else pass_cnt++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        hist.delete();
    endtask

    task automatic test_impulse();
        apply_reset();
        impulse_run("impulse");
    endtask

    task automatic test_timing();
        logic [AW-1:0] exp_addr;
        apply_reset();
        set_random_coeffs();
        send_sample(123);
        total_cnt++; if (coeffaddress !== '0) $display("FAIL timing_addr k=0: got %0d, required 0", coeffaddress); else pass_cnt++;
        total_cnt++; if (busy !== 1'b1)       $display("FAIL timing_busy k=0: got %b, required 1", busy); else pass_cnt++;
        for (int k = 1; k <= 67; k++) begin
            @(posedge clock);
            #1;
            exp_addr = (k <= 63) ? AW'(k) : '0;
            total_cnt++;
            if (coeffaddress !== exp_addr)
                $display("FAIL timing_addr k=%0d: got %0d, required %0d", k, coeffaddress, exp_addr);
            else pass_cnt++;
            total_cnt++;
            if (busy !== (k <= 64))
                $display("FAIL timing_busy k=%0d: got %b, required %b", k, busy, (k <= 64));
            else pass_cnt++;
            total_cnt++;
            if (dout_valid !== (k == 66))
                $display("FAIL timing_valid k=%0d: got %b, required %b", k, dout_valid, (k == 66));
            else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        int n;
        logic signed [DW-1:0] exp_v;
        apply_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++)
                h[c][k] = (k == 0) ? -65536 : 0;
        send_sample(-32768);
        wait_out(n);
`ifdef PROFIR_SAT_EN
        exp_v = 16'sd32767;
`else
        exp_v = -16'sd32768;
`endif
        total_cnt++;
        if (n < 0) $display("FAIL sat_timeout: no dout_valid, required one");
        else pass_cnt++;
        for (int c = 0; c < NCH; c++) begin
            total_cnt++;
            if ($signed(dataout[c*DW +: DW]) !== exp_v)
                $display("FAIL sat ch%0d: got %0d, required %0d", c, $signed(dataout[c*DW +: DW]), exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_overrun();
        int n;
        int a, b, cs, d, e;
        apply_reset();
        set_random_coeffs();
        a  = int'($signed(16'($urandom)));
        b  = int'($signed(16'($urandom))) | 1;
        cs = int'($signed(16'($urandom)));
        d  = int'($signed(16'($urandom)));
        e  = int'($signed(16'($urandom)));
        send_sample(a);
        push_hist(a);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_first: got %b, required 0", overrun); else pass_cnt++;
        idle_cycles(64);
        send_sample(b);
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_pulse: got %b, required 1", overrun); else pass_cnt++;
        send_sample(cs);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_one_cycle: got %b, required 0", overrun); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b1) $display("FAIL ovr_valid: got %b, required 1", dout_valid); else pass_cnt++;
        check_outputs("ovr_inflight");
        push_hist(cs);
        wait_out(n);
        total_cnt++; if (n < 0) $display("FAIL ovr_timeout: no dout_valid, required one"); else pass_cnt++;
        check_outputs("ovr_dropped");
        send_sample(d);
        push_hist(d);
        idle_cycles(65);
        send_sample(e);
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_spacing66: got %b, required 0", overrun); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b1) $display("FAIL ovr_valid66: got %b, required 1", dout_valid); else pass_cnt++;
        check_outputs("ovr_d");
        push_hist(e);
        wait_out(n);
        total_cnt++; if (n < 0) $display("FAIL ovr_timeout_e: no dout_valid, required one"); else pass_cnt++;
        check_outputs("ovr_e");
    endtask

    task automatic test_reset_mid_run();
        int n;
        int seen;
        bit hit;
        apply_reset();
        set_impulse();
        send_sample(500);
        wait_out(n);
        send_sample(700);
        wait_out(n);
        total_cnt++;
        if ($signed(dataout[0 +: DW]) !== 16'sd700)
            $display("FAIL rst_pre ch0: got %0d, required 700", $signed(dataout[0 +: DW]));
        else pass_cnt++;
        send_sample(300);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (coeffaddress == AW'(30)) hit = 1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        total_cnt++; if (!hit) $display("FAIL rst_addr30: address 30 not seen, required"); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (dataout !== '0)      $display("FAIL rst_dataout: got %h, required 0", dataout); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0)       $display("FAIL rst_busy: got %b, required 0", busy); else pass_cnt++;
        total_cnt++; if (coeffaddress !== '0) $display("FAIL rst_coeffaddress: got %0d, required 0", coeffaddress); else pass_cnt++;
        total_cnt++; if (dout_valid !== 1'b0) $display("FAIL rst_dout_valid: got %b, required 0", dout_valid); else pass_cnt++;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        hist.delete();
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            if (dout_valid) seen++;
        end
        total_cnt++; if (seen != 0) $display("FAIL rst_no_valid: got %0d strobes, required 0", seen); else pass_cnt++;
        impulse_run("rst_impulse");
    endtask

    task automatic test_random();
        int n;
        int s;
        apply_reset();
        set_random_coeffs();
        for (int i = 0; i < 512; i++) begin
            s = int'($signed(16'($urandom)));
            send_sample(s);
            push_hist(s);
            wait_out(n);
            total_cnt++;
            if (n != 66) $display("FAIL rand_latency strobe %0d: got %0d, required 66", i, n);
            else pass_cnt++;
            check_outputs("rand");
            idle_cycles($urandom_range(0, 3));
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NTAPS; k++)
                h[c][k] = 0;
        test_reset();
        test_impulse();
        test_timing();
        test_saturation();
        test_overrun();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
